// File: rtl/mem_fetch_ctrl.sv
// mem_fetch_ctrl: PC owner and fetch/load/store sequencer in front of a synchronous-read MEM.
// Optional branch support (pc_load/pc_target) is enabled by defining MEM_FETCH_PC_LOAD_EN.
module mem_fetch_ctrl #(
    parameter int unsigned AW       = 9,
    parameter int unsigned DW       = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_cmd,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] data_out,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ack,
    input  logic          fetch_req,
`ifdef MEM_FETCH_PC_LOAD_EN
    input  logic          pc_load,
    input  logic [AW-1:0] pc_target,
`endif
    input  logic          ls_req,
    input  logic          ls_write,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_done,
    output logic [DW-1:0] ls_rdata,
    output logic [AW-1:0] pc,
    output logic          addr_err
);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_NONE  = 2'b10;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_IF1  = 3'd1;
    localparam logic [2:0] S_IF2  = 3'd2;
    localparam logic [2:0] S_DISP = 3'd3;
    localparam logic [2:0] S_IDLE = 3'd4;
    localparam logic [2:0] S_LD1  = 3'd5;
    localparam logic [2:0] S_LD2  = 3'd6;
    localparam logic [2:0] S_ST   = 3'd7;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] r_ls_addr;
    logic [DW-1:0] r_ls_wdata;
    logic [DW-1:0] r_instr;
    logic          r_instr_valid;
    logic          r_ls_done;
    logic [DW-1:0] r_ls_rdata;
    logic          r_addr_err;

    logic [AW-1:0] w_mem_addr;
    logic [1:0]    w_mem_cmd;
    logic [DW-1:0] w_write_data;
    logic          w_ack;
    logic          w_ls_start;

    assign w_ack      = (r_state == S_DISP) && instr_ack;
    assign w_ls_start = (r_state == S_IDLE) && ls_req;

`ifdef MEM_FETCH_PC_LOAD_EN
    assign w_pc_next = pc_load ? pc_target : r_pc + AW'(1);
`else
    assign w_pc_next = r_pc + AW'(1);
`endif

    // Load/store has priority over fetch in S_IDLE; fetch_req is expected to stay high.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RST:  w_next_state = S_IF1;
            S_IF1:  w_next_state = S_IF2;
            S_IF2:  w_next_state = S_DISP;
            S_DISP: if (instr_ack) w_next_state = S_IDLE;
            S_IDLE: begin
                if (ls_req)         w_next_state = ls_write ? S_ST : S_LD1;
                else if (fetch_req) w_next_state = S_IF1;
            end
            S_LD1:  w_next_state = S_LD2;
            S_LD2:  w_next_state = S_IDLE;
            S_ST:   w_next_state = S_IDLE;
            default: w_next_state = S_RST;
        endcase
    end

    always_comb begin
        w_mem_addr   = '0;
        w_mem_cmd    = CMD_NONE;
        w_write_data = '0;
        case (r_state)
            S_IF1, S_IF2: begin
                w_mem_addr = r_pc;
                w_mem_cmd  = CMD_READ;
            end
            S_LD1, S_LD2: begin
                w_mem_addr = r_ls_addr;
                w_mem_cmd  = CMD_READ;
            end
            S_ST: begin
                w_mem_addr   = r_ls_addr;
                w_mem_cmd    = CMD_WRITE;
                w_write_data = r_ls_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RST;
            r_pc          <= AW'(RESET_PC);
            r_ls_addr     <= '0;
            r_ls_wdata    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_ls_done     <= 1'b0;
            r_ls_rdata    <= '0;
            r_addr_err    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ls_done <= 1'b0;
            // Request fields are captured once; later CPU changes have no effect.
            if (w_ls_start) begin
                r_ls_addr  <= ls_addr;
                r_ls_wdata <= ls_wdata;
            end
            if (r_state == S_IF2) begin
                r_instr       <= data_out;
                r_instr_valid <= 1'b1;
            end
            if (w_ack) begin
                r_instr_valid <= 1'b0;
                r_pc          <= w_pc_next;
            end
            if (r_state == S_LD2) begin
                r_ls_rdata <= data_out;
                r_ls_done  <= 1'b1;
            end
            if (r_state == S_ST) r_ls_done <= 1'b1;
            if ((w_mem_cmd != CMD_NONE) && w_mem_addr[AW-1]) r_addr_err <= 1'b1;
        end
    end

    assign mem_addr    = w_mem_addr;
    assign mem_cmd     = w_mem_cmd;
    assign write_data  = w_write_data;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign ls_done     = r_ls_done;
    assign ls_rdata    = r_ls_rdata;
    assign pc          = r_pc;
    assign addr_err    = r_addr_err;

endmodule
